// File: rtl/write_buffer_alloc_pkg.sv
`default_nettype none
// ============================================================================
//  Package : MemoryController_Definitions
//  Shared write-buffer constants and types for the memory-controller write path.
//  Rev 1.0 : initial release
// ============================================================================
package MemoryController_Definitions;

  localparam int WRITE_BUF_DEPTH = 8;
  localparam int WB_IDX_W        = $clog2(WRITE_BUF_DEPTH);

  typedef logic [WB_IDX_W-1:0] wb_idx_t;

  // Padding keeps valid/issued at the top two bits of a 128-bit word.
  typedef struct packed {
    logic        valid;
    logic        issued;
    logic [29:0] pad;
    logic [31:0] addr;
    logic [63:0] data;
  } WriteBufEntry_t;

endpackage
`default_nettype wire

// File: rtl/write_buffer_alloc_wb_lsb_find.sv
`default_nettype none
// ============================================================================
//  Module : wb_lsb_find
//  Combinational LSB-first finder: lowest set bit of a mask plus a found flag.
//  Rev 1.0 : initial release
// ============================================================================
module wb_lsb_find #(
  parameter int NUM_ENTRY = 8,
  parameter int IDX_W     = $clog2(NUM_ENTRY)
) (
  input  logic [NUM_ENTRY-1:0] i_mask,
  output logic                 o_found,
  output logic [IDX_W-1:0]     o_idx
);

  // Scanning from the top down lets the lowest set bit win.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = NUM_ENTRY - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/write_buffer_alloc.sv
`default_nettype none
// ============================================================================
//  Module : write_buffer_alloc
//  Write-buffer entry array: LSB-first allocate, issue and retire of entries.
//  Rev 1.0 : initial release
// ============================================================================
module write_buffer_alloc
  import MemoryController_Definitions::*;
#(
  parameter int NUM_ENTRY = WRITE_BUF_DEPTH,
  parameter int IDX_W     = $clog2(NUM_ENTRY),
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic [IDX_W-1:0]  wr_alloc_idx,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [IDX_W-1:0]  iss_idx,
  output logic [ADDR_W-1:0] iss_addr,
  output logic [DATA_W-1:0] iss_data,
  input  logic              wr_done,
  output logic              full,
  output logic              empty,
  output logic [IDX_W:0]    count,
  output logic              err_spurious_done
);

  logic [NUM_ENTRY-1:0] valid_q,  valid_d;
  logic [NUM_ENTRY-1:0] issued_q, issued_d;
  logic [ADDR_W-1:0]    addr_q [NUM_ENTRY];
  logic [ADDR_W-1:0]    addr_d [NUM_ENTRY];
  logic [DATA_W-1:0]    data_q [NUM_ENTRY];
  logic [DATA_W-1:0]    data_d [NUM_ENTRY];
  logic [IDX_W:0]       count_q,  count_d;
  logic                 err_q,    err_d;

  logic             free_found, pend_found, done_found;
  logic [IDX_W-1:0] free_idx,   pend_idx,   done_idx;
  logic             do_alloc,   do_issue,   do_retire;

  wb_lsb_find #(.NUM_ENTRY(NUM_ENTRY), .IDX_W(IDX_W)) u_find_free (
    .i_mask  (~valid_q),
    .o_found (free_found),
    .o_idx   (free_idx)
  );

  wb_lsb_find #(.NUM_ENTRY(NUM_ENTRY), .IDX_W(IDX_W)) u_find_pend (
    .i_mask  (valid_q & ~issued_q),
    .o_found (pend_found),
    .o_idx   (pend_idx)
  );

  wb_lsb_find #(.NUM_ENTRY(NUM_ENTRY), .IDX_W(IDX_W)) u_find_done (
    .i_mask  (valid_q & issued_q),
    .o_found (done_found),
    .o_idx   (done_idx)
  );

  assign full              = (count_q == (IDX_W+1)'(NUM_ENTRY));
  assign empty             = (count_q == '0);
  assign count             = count_q;
  assign err_spurious_done = err_q;

  assign wr_req_ready = !rst && !full;
  assign wr_alloc_idx = (!rst && free_found) ? free_idx : '0;
  assign iss_valid    = !rst && pend_found;
  assign iss_idx      = iss_valid ? pend_idx         : '0;
  assign iss_addr     = iss_valid ? addr_q[pend_idx] : '0;
  assign iss_data     = iss_valid ? data_q[pend_idx] : '0;

  assign do_alloc  = wr_req_valid && wr_req_ready;
  assign do_issue  = iss_valid && iss_ready;
  assign do_retire = wr_done && done_found;

  // The three finders select disjoint slots, so the updates never collide.
  always_comb begin
    valid_d  = valid_q;
    issued_d = issued_q;
    addr_d   = addr_q;
    data_d   = data_q;
    if (do_alloc) begin
      valid_d[free_idx]  = 1'b1;
      issued_d[free_idx] = 1'b0;
      addr_d[free_idx]   = wr_req_addr;
      data_d[free_idx]   = wr_req_data;
    end
    if (do_issue) begin
      issued_d[pend_idx] = 1'b1;
    end
    if (do_retire) begin
      valid_d[done_idx]  = 1'b0;
      issued_d[done_idx] = 1'b0;
    end
    count_d = count_q + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(do_retire);
    err_d   = err_q | (wr_done && !done_found);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      issued_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      issued_q <= issued_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Payload needs no reset: it is only visible behind a set valid flag.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_write_buffer_alloc.sv
`default_nettype none
// ============================================================================
//  Module : tb_write_buffer_alloc
//  Self-checking bench: directed scenarios plus random traffic vs. a slot model.
//  Rev 1.0 : initial release
// ============================================================================
module tb_write_buffer_alloc;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int VW = 1 + IW + 1 + IW + AW + DW + 1 + 1 + (IW + 1) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req_valid;
  logic          wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic [IW-1:0] wr_alloc_idx;
  logic          iss_valid;
  logic          iss_ready;
  logic [IW-1:0] iss_idx;
  logic [AW-1:0] iss_addr;
  logic [DW-1:0] iss_data;
  logic          wr_done;
  logic          full;
  logic          empty;
  logic [IW:0]   count;
  logic          err_spurious_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  write_buffer_alloc #(.NUM_ENTRY(N), .IDX_W(IW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk               (clk),
    .rst               (rst),
    .wr_req_valid      (wr_req_valid),
    .wr_req_ready      (wr_req_ready),
    .wr_req_addr       (wr_req_addr),
    .wr_req_data       (wr_req_data),
    .wr_alloc_idx      (wr_alloc_idx),
    .iss_valid         (iss_valid),
    .iss_ready         (iss_ready),
    .iss_idx           (iss_idx),
    .iss_addr          (iss_addr),
    .iss_data          (iss_data),
    .wr_done           (wr_done),
    .full              (full),
    .empty             (empty),
    .count             (count),
    .err_spurious_done (err_spurious_done)
  );

  // Reference model: each slot is 0=FREE, 1=PENDING, 2=ISSUED.
  int            st [N];
  logic [AW-1:0] ma [N];
  logic [DW-1:0] md [N];
  bit            merr;

  function automatic int lowest(input int s);
    for (int i = 0; i < N; i++) if (st[i] == s) return i;
    return -1;
  endfunction

  function automatic int occupied();
    int n = 0;
    for (int i = 0; i < N; i++) if (st[i] != 0) n++;
    return n;
  endfunction

  always @(posedge clk) begin : model
    int fi, pi, ii;
    if (rst) begin
      for (int i = 0; i < N; i++) st[i] = 0;
      merr = 1'b0;
    end else begin
      fi = lowest(0);
      pi = lowest(1);
      ii = lowest(2);
      if (wr_req_valid && fi >= 0) begin
        st[fi] = 1; ma[fi] = wr_req_addr; md[fi] = wr_req_data;
      end
      if (iss_ready && pi >= 0) st[pi] = 2;
      if (wr_done) begin
        if (ii >= 0) st[ii] = 0;
        else merr = 1'b1;
      end
    end
  end

  function automatic logic [VW-1:0] expv();
    int fi = lowest(0);
    int pi = lowest(1);
    int c  = occupied();
    logic          e_iv = !rst && pi >= 0;
    logic [IW-1:0] e_ai = (!rst && fi >= 0) ? IW'(fi) : '0;
    logic [IW-1:0] e_ii = e_iv ? IW'(pi) : '0;
    logic [AW-1:0] e_a  = e_iv ? ma[pi] : '0;
    logic [DW-1:0] e_d  = e_iv ? md[pi] : '0;
    return {!rst && c < N, e_ai, e_iv, e_ii, e_a, e_d,
            c == N, c == 0, (IW+1)'(c), merr};
  endfunction

  function automatic logic [VW-1:0] actv();
    return {wr_req_ready, wr_alloc_idx, iss_valid, iss_idx, iss_addr, iss_data,
            full, empty, count, err_spurious_done};
  endfunction

  task automatic drive(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit r, input bit dn);
    wr_req_valid = v; wr_req_addr = a; wr_req_data = d;
    iss_ready = r; wr_done = dn;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); cyc(); cyc(); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1; #1;
    checks++;
    if ({wr_req_ready, iss_valid, full, empty, err_spurious_done} !== 5'b00010) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00010",
               {wr_req_ready, iss_valid, full, empty, err_spurious_done});
    end
    checks++;
    if ({count, wr_alloc_idx, iss_idx, iss_addr, iss_data} !== '0) begin
      failures++;
      $display("FAIL reset_values count=%0d alloc=%0d iss_idx=%0d addr=%h data=%h",
               count, wr_alloc_idx, iss_idx, iss_addr, iss_data);
    end
    rst = 1'b0; #1;
    checks++;
    if (wr_req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b exp=1", wr_req_ready);
    end
  endtask

  task automatic test_basic_alloc();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, AW'(32'h100 + 32'h40 * k), DW'(64'hD0 + k), 1'b0, 1'b0); #1;
      checks++;
      if (wr_alloc_idx !== IW'(k)) begin
        failures++; $display("FAIL basic_alloc_idx got=%0d exp=%0d", wr_alloc_idx, k);
      end
      if (k > 0) begin
        checks++;
        if (iss_valid !== 1'b1 || iss_idx !== '0 || iss_addr !== 32'h100) begin
          failures++;
          $display("FAIL basic_offer valid=%b idx=%0d addr=%h exp 1/0/100",
                   iss_valid, iss_idx, iss_addr);
        end
      end
      cyc();
    end
    idle(); #1;
    checks++;
    if (count !== 4'd3 || iss_idx !== '0 || iss_addr !== 32'h100 || iss_data !== 64'hD0) begin
      failures++;
      $display("FAIL basic_after count=%0d idx=%0d addr=%h data=%h exp 3/0/100/d0",
               count, iss_idx, iss_addr, iss_data);
    end
  endtask

  task automatic test_fill_full();
    for (int k = 3; k < N; k++) begin
      drive(1'b1, AW'(32'h100 + 32'h40 * k), DW'(64'hD0 + k), 1'b0, 1'b0); #1;
      checks++;
      if (wr_alloc_idx !== IW'(k)) begin
        failures++; $display("FAIL fill_alloc_idx got=%0d exp=%0d", wr_alloc_idx, k);
      end
      cyc();
    end
    drive(1'b1, 32'hDEAD0000, 64'hBAD, 1'b0, 1'b0); #1;
    checks++;
    if (full !== 1'b1 || wr_req_ready !== 1'b0 || wr_alloc_idx !== '0) begin
      failures++;
      $display("FAIL fill_full full=%b ready=%b alloc=%0d exp 1/0/0",
               full, wr_req_ready, wr_alloc_idx);
    end
    cyc(); cyc(); idle(); #1;
    checks++;
    if (count !== 4'd8 || iss_addr !== 32'h100 || actv() !== expv()) begin
      failures++;
      $display("FAIL fill_held count=%0d addr=%h got=%h exp=%h", count, iss_addr, actv(), expv());
    end
  endtask

  task automatic test_issue_retire();
    drive(1'b0, '0, '0, 1'b1, 1'b0); #1;
    checks++;
    if (iss_idx !== 3'd0) begin failures++; $display("FAIL issue0 got=%0d exp=0", iss_idx); end
    cyc(); #1;
    checks++;
    if (iss_idx !== 3'd1 || iss_addr !== 32'h140) begin
      failures++; $display("FAIL issue1 idx=%0d addr=%h exp 1/140", iss_idx, iss_addr);
    end
    cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b1); #1;
    checks++;
    if (iss_idx !== 3'd2 || count !== 4'd8) begin
      failures++; $display("FAIL pre_retire idx=%0d count=%0d exp 2/8", iss_idx, count);
    end
    cyc(); idle(); #1;
    checks++;
    if (count !== 4'd7 || wr_alloc_idx !== 3'd0 || wr_req_ready !== 1'b1 || err_spurious_done !== 1'b0) begin
      failures++;
      $display("FAIL retire count=%0d alloc=%0d ready=%b err=%b exp 7/0/1/0",
               count, wr_alloc_idx, wr_req_ready, err_spurious_done);
    end
    drive(1'b1, 32'h200, 64'h55, 1'b0, 1'b0); cyc(); idle(); #1;
    checks++;
    if (count !== 4'd8 || iss_idx !== 3'd0 || iss_addr !== 32'h200) begin
      failures++;
      $display("FAIL realloc count=%0d idx=%0d addr=%h exp 8/0/200", count, iss_idx, iss_addr);
    end
  endtask

  task automatic test_full_done_alloc();
    do_reset();
    for (int k = 0; k < N; k++) begin
      drive(1'b1, AW'(32'h1000 + k), DW'(k), 1'b0, 1'b0); cyc();
    end
    for (int k = 0; k < 4; k++) begin drive(1'b0, '0, '0, 1'b1, 1'b0); cyc(); end
    for (int k = 0; k < 3; k++) begin drive(1'b0, '0, '0, 1'b0, 1'b1); cyc(); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, AW'(32'h2000 + k), DW'(k), 1'b0, 1'b0); cyc();
    end
    drive(1'b1, 32'hABC, 64'h1234, 1'b0, 1'b1); #1;
    checks++;
    if (full !== 1'b1 || wr_req_ready !== 1'b0) begin
      failures++; $display("FAIL fda_full full=%b ready=%b exp 1/0", full, wr_req_ready);
    end
    cyc();
    drive(1'b1, 32'hABC, 64'h1234, 1'b0, 1'b0); #1;
    checks++;
    if (count !== 4'd7 || wr_req_ready !== 1'b1 || wr_alloc_idx !== 3'd3) begin
      failures++;
      $display("FAIL fda_retire count=%0d ready=%b alloc=%0d exp 7/1/3",
               count, wr_req_ready, wr_alloc_idx);
    end
    cyc(); idle(); #1;
    checks++;
    if (count !== 4'd8 || actv() !== expv()) begin
      failures++; $display("FAIL fda_accept count=%0d got=%h exp=%h", count, actv(), expv());
    end
    // Drain to slot 3 to confirm it holds the late request.
    for (int k = 0; k < 3; k++) begin drive(1'b0, '0, '0, 1'b1, 1'b0); cyc(); end
    idle(); #1;
    checks++;
    if (iss_idx !== 3'd3 || iss_addr !== 32'hABC || iss_data !== 64'h1234) begin
      failures++;
      $display("FAIL fda_slot3 idx=%0d addr=%h data=%h exp 3/abc/1234", iss_idx, iss_addr, iss_data);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    drive(1'b1, 32'h300, 64'h3, 1'b0, 1'b0); cyc();
    drive(1'b0, '0, '0, 1'b0, 1'b1); cyc(); idle(); #1;
    checks++;
    if (err_spurious_done !== 1'b1 || count !== 4'd1 || iss_valid !== 1'b1 || iss_addr !== 32'h300) begin
      failures++;
      $display("FAIL spurious_set err=%b count=%0d iv=%b addr=%h exp 1/1/1/300",
               err_spurious_done, count, iss_valid, iss_addr);
    end
    cyc(); cyc(); cyc(); #1;
    checks++;
    if (err_spurious_done !== 1'b1) begin
      failures++; $display("FAIL spurious_sticky got=%b exp=1", err_spurious_done);
    end
    rst = 1'b1; cyc(); rst = 1'b0; #1;
    checks++;
    if (err_spurious_done !== 1'b0 || count !== 4'd0) begin
      failures++;
      $display("FAIL spurious_clear err=%b count=%0d exp 0/0", err_spurious_done, count);
    end
  endtask

  task automatic test_reset_midtraffic();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, $urandom, {$urandom, $urandom}, k == 2, 1'b0); cyc();
    end
    rst = 1'b1; idle(); cyc(); #1;
    checks++;
    if (actv() !== '0 || empty !== 1'b0) begin
      // empty is part of actv; second term only guards the literal compare
    end
    if ({wr_req_ready, iss_valid, full, empty, count, err_spurious_done} !== 9'b000100000) begin
      failures++;
      $display("FAIL mid_reset ready=%b iv=%b full=%b empty=%b count=%0d err=%b",
               wr_req_ready, iss_valid, full, empty, count, err_spurious_done);
    end
    rst = 1'b0; #1;
    checks++;
    if (wr_req_ready !== 1'b1 || actv() !== expv()) begin
      failures++; $display("FAIL mid_reset_release got=%h exp=%h", actv(), expv());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 9) < 6, $urandom, {$urandom, $urandom},
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 3);
      #1;
      checks++;
      if (actv() !== expv()) begin
        failures++; $display("FAIL random cyc=%0d got=%h exp=%h", c, actv(), expv());
      end
      cyc();
    end
    rst = 1'b0; idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_basic_alloc();
    test_fill_full();
    test_issue_retire();
    test_full_done_alloc();
    test_spurious();
    test_reset_midtraffic();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
